// File: rtl/fifo_sync_par.sv
// rtl/fifo_sync_par.sv - parametrised single-clock FIFO with exact count, level flags, sticky errors, parity and FWFT
module fifo_sync_par #(
    parameter int FIFO_WIDTH   = 64,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_BITS    = $clog2(FIFO_DEPTH),
    parameter int AFULL_LEVEL  = FIFO_DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1,
    parameter int FWFT         = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  write_n,
    input  logic                  read_n,
    input  logic                  parity_inject,
    input  logic                  clr_err,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  parity_err,
    output logic [FIFO_BITS:0]    fifo_counter,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_afull,
    output logic                  fifo_aempty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [FIFO_BITS:0]   DEPTH_C  = (FIFO_BITS+1)'(FIFO_DEPTH);
    localparam logic [FIFO_BITS:0]   AFULL_C  = (FIFO_BITS+1)'(AFULL_LEVEL);
    localparam logic [FIFO_BITS:0]   AEMPTY_C = (FIFO_BITS+1)'(AEMPTY_LEVEL);
    localparam logic [FIFO_BITS-1:0] PTR_MAX  = FIFO_BITS'(FIFO_DEPTH - 1);

    // Each word carries its even-parity bit in the top position
    logic [FIFO_WIDTH:0]   mem [FIFO_DEPTH];
    logic [FIFO_BITS-1:0]  wr_ptr;
    logic [FIFO_BITS-1:0]  rd_ptr;
    logic [FIFO_BITS:0]    count;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [FIFO_WIDTH:0]   head;
    logic                  head_perr;

    assign rd_acc    = !read_n && (count != '0);
    assign wr_acc    = !write_n && ((count < DEPTH_C) || rd_acc);
    assign head      = mem[rd_ptr];
    assign head_perr = ^head;

    assign fifo_counter = count;
    assign fifo_full    = (count == DEPTH_C);
    assign fifo_empty   = (count == '0);
    assign fifo_afull   = (count >= AFULL_C);
    assign fifo_aempty  = (count <= AEMPTY_C);

    // Storage write; memory is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= {(^data_in) ^ parity_inject, data_in};
        end
    end

    // Pointers wrap explicitly at FIFO_DEPTH-1 so odd depths work; count tracks net accepts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (!write_n && !wr_acc) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (!read_n && (count == '0)) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out   = head[FIFO_WIDTH-1:0];
            assign parity_err = !fifo_empty && head_perr;
        end else begin : g_reg
            logic [FIFO_WIDTH-1:0] data_q;
            logic                  perr_q;

            // Registered read: capture the head word and its parity check on each accepted read
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_q <= '0;
                    perr_q <= 1'b0;
                end else if (rd_acc) begin
                    data_q <= head[FIFO_WIDTH-1:0];
                    perr_q <= head_perr;
                end
            end

            assign data_out   = data_q;
            assign parity_err = perr_q;
        end
    endgenerate

endmodule
